// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: walks the frame buffer and issues 1- or 4-beat burst reads into the pixel FIFOs.
// Optional data-phase watchdog is compiled in when FETCH_TIMEOUT_EN is defined.
module vid_fetch_sched #(
    parameter int         FIFO_DEPTH     = 16,
    parameter int         URGENT_LVL     = 4,
    parameter logic [3:0] TARGET_ID      = 4'h0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [31:0] base_addr,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize_words,
    input  logic [12:0] vsize,
    input  logic [4:0]  fifo_level,
    input  logic        ackin,
    input  logic [2:0]  cmdin,
    input  logic [31:0] addrdatain,
    output logic [1:0]  reqout,
    output logic [3:0]  reqtar,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic        fifo_push,
    output logic [23:0] fifo_data,
    output logic        frame_done,
    output logic        frame_overrun,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        REQ,
        ADDR,
        DATA,
        ADVANCE
    } state_t;

    state_t      state;
    logic [31:0] line_ptr;
    logic [31:0] addr;
    logic [12:0] words_left;
    logic [12:0] lines_left;
    logic [12:0] hsize_q;
    logic [2:0]  beat_cnt;
    logic        restart_pending;
`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wd_cnt;
`endif

    logic [2:0]  beats;
    logic [1:0]  len_code;
    logic        room_ok;
    logic        urgent;
    logic        start_ok;
    logic        line_end;
    logic        last_line;
    logic [31:0] next_addr;

    always_comb begin
        beats     = (words_left >= 13'd4) ? 3'd4 : 3'd1;
        len_code  = (beats == 3'd4) ? 2'b10 : 2'b00;
        room_ok   = (FIFO_DEPTH - int'(fifo_level)) >= int'(beats);
        urgent    = int'(fifo_level) < URGENT_LVL;
        start_ok  = enable && (hsize_words != 13'd0) && (vsize != 13'd0);
        line_end  = (words_left == 13'(beats));
        last_line = line_end && (lines_left == 13'd1);
        next_addr = addr + {27'd0, beats, 2'b00};
    end

    // Outputs are registered alongside the state, so every transition also loads what the next state drives.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            line_ptr        <= '0;
            addr            <= '0;
            words_left      <= '0;
            lines_left      <= '0;
            hsize_q         <= '0;
            beat_cnt        <= '0;
            restart_pending <= 1'b0;
            reqout          <= 2'b00;
            reqtar          <= 4'h0;
            cmdout          <= 3'b000;
            lenout          <= 2'b00;
            addrdataout     <= '0;
            fifo_push       <= 1'b0;
            fifo_data       <= '0;
            frame_done      <= 1'b0;
            frame_overrun   <= 1'b0;
            timeout_err     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wd_cnt          <= '0;
`endif
        end else begin
            fifo_push   <= 1'b0;
            frame_done  <= 1'b0;
            cmdout      <= 3'b000;
            lenout      <= 2'b00;
            addrdataout <= '0;

            // A restart requested mid-frame is deferred so the bus burst in flight always completes.
            if (frame_start && state != IDLE && state != ADVANCE) begin
                frame_overrun   <= 1'b1;
                restart_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    restart_pending <= 1'b0;
                    reqout          <= 2'b00;
                    reqtar          <= 4'h0;
                    if (frame_start && start_ok) begin
                        line_ptr      <= base_addr;
                        addr          <= base_addr;
                        words_left    <= hsize_words;
                        hsize_q       <= hsize_words;
                        lines_left    <= vsize;
                        frame_overrun <= 1'b0;
                        timeout_err   <= 1'b0;
                        state         <= WAIT_ROOM;
                    end
                end

                WAIT_ROOM: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (room_ok) begin
                        reqout <= urgent ? 2'b11 : 2'b01;
                        reqtar <= TARGET_ID;
                        state  <= REQ;
                    end
                end

                REQ: begin
                    if (ackin) begin
                        reqout      <= 2'b00;
                        reqtar      <= 4'h0;
                        cmdout      <= 3'b010;
                        lenout      <= len_code;
                        addrdataout <= addr;
                        beat_cnt    <= '0;
                        state       <= ADDR;
                    end else begin
                        reqout <= urgent ? 2'b11 : 2'b01;
                    end
                end

                ADDR: begin
`ifdef FETCH_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= DATA;
                end

                DATA: begin
                    if (cmdin == 3'b011) begin
                        fifo_push <= 1'b1;
                        fifo_data <= addrdatain[23:0];
                        beat_cnt  <= beat_cnt + 3'd1;
`ifdef FETCH_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                        if (beat_cnt == beats - 3'd1)
                            state <= ADVANCE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end

                ADVANCE: begin
                    if (restart_pending || (frame_start && !last_line)) begin
                        frame_overrun   <= 1'b1;
                        restart_pending <= 1'b0;
                        if (start_ok) begin
                            line_ptr   <= base_addr;
                            addr       <= base_addr;
                            words_left <= hsize_words;
                            hsize_q    <= hsize_words;
                            lines_left <= vsize;
                            state      <= WAIT_ROOM;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (last_line) begin
                        frame_done <= 1'b1;
                        lines_left <= '0;
                        words_left <= '0;
                        // A new frame landing exactly on the last burst is a clean start, not an overrun.
                        if (frame_start && start_ok) begin
                            line_ptr      <= base_addr;
                            addr          <= base_addr;
                            words_left    <= hsize_words;
                            hsize_q       <= hsize_words;
                            lines_left    <= vsize;
                            frame_overrun <= 1'b0;
                            timeout_err   <= 1'b0;
                            state         <= WAIT_ROOM;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (line_end) begin
                            lines_left <= lines_left - 13'd1;
                            line_ptr   <= line_ptr + lineinc;
                            addr       <= line_ptr + lineinc;
                            words_left <= hsize_q;
                        end else begin
                            addr       <= next_addr;
                            words_left <= words_left - 13'(beats);
                        end
                        state <= enable ? WAIT_ROOM : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_fetch_sched.sv
// Directed testbench for vid_fetch_sched: drives a simple bus responder by hand and checks bursts, pushes and flags.
module tb_vid_fetch_sched;

`ifdef FETCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif
    localparam logic [3:0] TB_TARGET = 4'h5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        frame_start;
    logic [31:0] base_addr;
    logic [31:0] lineinc;
    logic [12:0] hsize_words;
    logic [12:0] vsize;
    logic [4:0]  fifo_level;
    logic        ackin;
    logic [2:0]  cmdin;
    logic [31:0] addrdatain;
    logic [1:0]  reqout;
    logic [3:0]  reqtar;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic        fifo_push;
    logic [23:0] fifo_data;
    logic        frame_done;
    logic        frame_overrun;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int push_cnt = 0;
    int done_cnt = 0;

    vid_fetch_sched #(
        .FIFO_DEPTH    (16),
        .URGENT_LVL    (4),
        .TARGET_ID     (TB_TARGET),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .frame_start  (frame_start),
        .base_addr    (base_addr),
        .lineinc      (lineinc),
        .hsize_words  (hsize_words),
        .vsize        (vsize),
        .fifo_level   (fifo_level),
        .ackin        (ackin),
        .cmdin        (cmdin),
        .addrdatain   (addrdatain),
        .reqout       (reqout),
        .reqtar       (reqtar),
        .cmdout       (cmdout),
        .lenout       (lenout),
        .addrdataout  (addrdataout),
        .fifo_push    (fifo_push),
        .fifo_data    (fifo_data),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_push)  push_cnt++;
        if (frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] inc,
                               input logic [12:0] hs, input logic [12:0] vs);
        base_addr   = base;
        lineinc     = inc;
        hsize_words = hs;
        vsize       = vs;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Waits (bounded) for the ADDR cycle, checks it, then feeds nbeats data beats and checks each push.
    task automatic run_burst(input string name, input logic [31:0] exp_addr, input logic [1:0] exp_len,
                             input int nbeats, input logic [23:0] seed, input int fs_beat, input bit gap);
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (cmdout == 3'b010) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s addr_cycle: got cmdout=%b, required 010 within 50 cycles", name, cmdout);
            return;
        end
        checks++;
        if (addrdataout !== exp_addr) begin
            errors++;
            $display("[TB] FAIL %s addr: got %h, required %h", name, addrdataout, exp_addr);
        end
        checks++;
        if (lenout !== exp_len) begin
            errors++;
            $display("[TB] FAIL %s lenout: got %b, required %b", name, lenout, exp_len);
        end
        checks++;
        if (reqout !== 2'b00 || reqtar !== 4'h0) begin
            errors++;
            $display("[TB] FAIL %s bid_in_addr: got reqout=%b reqtar=%h, required 00/0", name, reqout, reqtar);
        end
        tick();
        if (gap) begin
            cmdin      = 3'b001;
            addrdatain = 32'hDEAD_BEEF;
            tick();
            checks++;
            if (fifo_push !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s ignored_cmd: got fifo_push=%b, required 0", name, fifo_push);
            end
        end
        for (int k = 0; k < nbeats; k++) begin
            logic [23:0] d;
            d           = seed + 24'(k);
            cmdin       = 3'b011;
            addrdatain  = {8'hA5, d};
            frame_start = (k == fs_beat);
            tick();
            frame_start = 1'b0;
            checks++;
            if (fifo_push !== 1'b1 || fifo_data !== d) begin
                errors++;
                $display("[TB] FAIL %s beat%0d: got push=%b data=%h, required push=1 data=%h",
                         name, k, fifo_push, fifo_data, d);
            end
        end
        cmdin      = 3'b000;
        addrdatain = '0;
    endtask

    task automatic expect_frame_done(input string name);
        tick();
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s frame_done: got %b, required 1", name, frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s frame_done_pulse: got %b, required 0", name, frame_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({reqout, reqtar, cmdout, lenout, addrdataout, fifo_push, fifo_data,
             frame_done, frame_overrun, timeout_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b tar=%h cmd=%b len=%b ad=%h push=%b data=%h done=%b ovr=%b to=%b, required all 0",
                     reqout, reqtar, cmdout, lenout, addrdataout, fifo_push, fifo_data,
                     frame_done, frame_overrun, timeout_err);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_linear_frame();
        int p0 = push_cnt;
        int d0 = done_cnt;
        start_frame(32'h1000, 32'h40, 13'd8, 13'd2);
        run_burst("lin_b0", 32'h1000, 2'b10, 4, 24'h000100, -1, 1'b0);
        run_burst("lin_b1", 32'h1010, 2'b10, 4, 24'h000200, -1, 1'b0);
        run_burst("lin_b2", 32'h1040, 2'b10, 4, 24'h000300, -1, 1'b0);
        run_burst("lin_b3", 32'h1050, 2'b10, 4, 24'h000400, -1, 1'b0);
        expect_frame_done("lin");
        tick();
        checks++;
        if (push_cnt - p0 != 16) begin
            errors++;
            $display("[TB] FAIL lin_pushes: got %0d, required 16", push_cnt - p0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL lin_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_partial_bursts();
        start_frame(32'h2000, 32'h100, 13'd6, 13'd1);
        run_burst("part_b0", 32'h2000, 2'b10, 4, 24'h123450, -1, 1'b1);
        run_burst("part_b1", 32'h2010, 2'b00, 1, 24'hFFFFFE, -1, 1'b0);
        run_burst("part_b2", 32'h2014, 2'b00, 1, 24'h00ABCD, -1, 1'b1);
        expect_frame_done("part");
        checks++;
        if (frame_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL part_overrun: got %b, required 0", frame_overrun);
        end
    endtask

    task automatic test_room_and_urgency();
        fifo_level = 5'd13;
        ackin      = 1'b0;
        start_frame(32'h3000, 32'h40, 13'd8, 13'd1);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (reqout !== 2'b00 || reqtar !== 4'h0) begin
            errors++;
            $display("[TB] FAIL room_hold: got reqout=%b reqtar=%h, required 00/0", reqout, reqtar);
        end
        fifo_level = 5'd12;
        tick();
        checks++;
        if (reqout !== 2'b01 || reqtar !== TB_TARGET) begin
            errors++;
            $display("[TB] FAIL bid_normal: got reqout=%b reqtar=%h, required 01/%h", reqout, reqtar, TB_TARGET);
        end
        fifo_level = 5'd2;
        tick();
        checks++;
        if (reqout !== 2'b11) begin
            errors++;
            $display("[TB] FAIL bid_urgent: got reqout=%b, required 11", reqout);
        end
        tick();
        checks++;
        if (reqout !== 2'b11 || cmdout !== 3'b000) begin
            errors++;
            $display("[TB] FAIL bid_hold: got reqout=%b cmdout=%b, required 11/000", reqout, cmdout);
        end
        ackin = 1'b1;
        run_burst("room_b0", 32'h3000, 2'b10, 4, 24'h0A0B0C, -1, 1'b0);
        run_burst("room_b1", 32'h3010, 2'b10, 4, 24'h0D0E0F, -1, 1'b0);
        expect_frame_done("room");
        fifo_level = 5'd0;
    endtask

    task automatic test_overrun_restart();
        int d0 = done_cnt;
        start_frame(32'h4000, 32'h100, 13'd8, 13'd2);
        run_burst("ovr_b0", 32'h4000, 2'b10, 4, 24'h111100, -1, 1'b0);
        run_burst("ovr_b1", 32'h4010, 2'b10, 4, 24'h222200, 1, 1'b0);
        checks++;
        if (frame_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_flag: got %b, required 1", frame_overrun);
        end
        run_burst("ovr_r0", 32'h4000, 2'b10, 4, 24'h333300, -1, 1'b0);
        run_burst("ovr_r1", 32'h4010, 2'b10, 4, 24'h444400, -1, 1'b0);
        run_burst("ovr_r2", 32'h4100, 2'b10, 4, 24'h555500, -1, 1'b0);
        run_burst("ovr_r3", 32'h4110, 2'b10, 4, 24'h666600, -1, 1'b0);
        expect_frame_done("ovr");
        checks++;
        if (done_cnt - d0 != 1 || frame_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_done_sticky: got done=%0d overrun=%b, required 1/1", done_cnt - d0, frame_overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        start_frame(32'h5000, 32'h40, 13'd4, 13'd1);
        run_burst("rst_b0", 32'h5000, 2'b10, 1, 24'h777700, 0, 1'b0);
        checks++;
        if (frame_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre_overrun: got %b, required 1", frame_overrun);
        end
        reset_n    = 1'b0;
        cmdin      = 3'b011;
        addrdatain = 32'h0088_8801;
        tick();
        checks++;
        if ({reqout, reqtar, cmdout, lenout, addrdataout, fifo_push, fifo_data,
             frame_done, frame_overrun, timeout_err} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_outputs: got req=%b cmd=%b push=%b data=%h ovr=%b, required all 0",
                     reqout, cmdout, fifo_push, fifo_data, frame_overrun);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            addrdatain = 32'h0088_8802 + 32'(k);
            tick();
            checks++;
            if (fifo_push !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_late_beat%0d: got fifo_push=%b, required 0", k, fifo_push);
            end
        end
        cmdin      = 3'b000;
        addrdatain = '0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cmdout !== 3'b000 || reqout !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_idle: got cmdout=%b reqout=%b, required 000/00", cmdout, reqout);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_cnt;
        start_frame(32'h6000, 32'h40, 13'd4, 13'd1);
        run_burst("to_b0", 32'h6000, 2'b10, 2, 24'h999900, -1, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_early: got timeout_err=%b, required 0", timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_flag: got timeout_err=%b, required 1", timeout_err);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (reqout !== 2'b00 || cmdout !== 3'b000 || done_cnt != d0 || timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_idle: got reqout=%b cmdout=%b done=%0d to=%b, required 00/000/0/1",
                     reqout, cmdout, done_cnt - d0, timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        start_frame(32'h6000, 32'h40, 13'd4, 13'd1);
        run_burst("nto_b0", 32'h6000, 2'b10, 2, 24'h999900, -1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (timeout_err !== 1'b0 || fifo_push !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nto_wait: got timeout_err=%b push=%b, required 0/0", timeout_err, fifo_push);
        end
        for (int k = 2; k < 4; k++) begin
            cmdin      = 3'b011;
            addrdatain = 32'h0099_9900 + 32'(k);
            tick();
            checks++;
            if (fifo_push !== 1'b1 || fifo_data !== 24'h999900 + 24'(k)) begin
                errors++;
                $display("[TB] FAIL nto_beat%0d: got push=%b data=%h, required 1/%h",
                         k, fifo_push, fifo_data, 24'h999900 + 24'(k));
            end
        end
        cmdin      = 3'b000;
        addrdatain = '0;
        expect_frame_done("nto");
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        frame_start = 1'b0;
        base_addr   = '0;
        lineinc     = '0;
        hsize_words = '0;
        vsize       = '0;
        fifo_level  = '0;
        ackin       = 1'b1;
        cmdin       = 3'b000;
        addrdatain  = '0;

        test_reset();
        test_linear_frame();
        test_partial_bursts();
        test_room_and_urgency();
        test_overrun_restart();
        test_reset_mid_burst();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
